fifo_pop_stream: RTL and testbench

Read-side adapter for fifo_simple. It drives the FIFO's pop/pop_data/empty interface and presents the data downstream as a valid/ready stream. A 2-entry output skid buffer hides the FIFO's one-cycle read latency, so the block sustains one word per cycle with full backpressure. It sits between any fifo_simple instance and a streaming consumer, for example a coprocessor datapath stage.

---
 rtl/fifo_pop_stream.sv | 81 ++++++++
 tb/tb_fifo_pop_stream.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: read-side adapter for fifo_simple.
// Pops words from the FIFO and presents them as a valid/ready stream.
// The FIFO returns data one cycle after the pop. A 2-entry skid buffer
// (head + tail) absorbs that delay, so one word per cycle flows under
// full backpressure.
module fifo_pop_stream #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  down_valid,
    input  logic                  down_ready,
    output logic [DATA_WIDTH-1:0] down_data,
    output logic [1:0]            buf_count
);

    // occ_q counts buffered words (0..2).
    // inflight_q marks a word arriving on fifo_data this cycle.
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    logic                  fire;
    logic [2:0]            pending;
    logic [1:0]            occ_after;

    // Pop decision: buffered plus in-flight words must never exceed the two slots,
    // unless a word leaves this same cycle.
    always_comb begin
        fire     = (occ_q != 2'd0) & down_ready;
        pending  = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_pop = !rst && !fifo_empty && ((pending < 3'd2) || fire);
    end

    // Next-state: dequeue first (tail moves to head), then land an arriving word
    // in the first free slot so order is preserved.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_after  = occ_q - {1'b0, fire};
        inflight_d = fifo_pop;
        if (fire) begin
            head_d = tail_q;
        end
        if (inflight_q) begin
            if (occ_after == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
        end
        occ_d = occ_after + {1'b0, inflight_q};
    end

    // State registers. Reset discards any buffered or in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Outputs come straight from registers. Head stays put while stalled.
    always_comb begin
        down_valid = (occ_q != 2'd0);
        down_data  = head_q;
        buf_count  = occ_q;
    end

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Testbench for fifo_pop_stream. A behavioural fifo_simple model feeds the DUT.
// Words pushed into the model are queued as expectations; a monitor
// process pops and compares on every downstream fire.
module tb_fifo_pop_stream;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] fifo_data;
    logic          down_valid;
    logic          down_ready;
    logic [DW-1:0] down_data;
    logic [1:0]    buf_count;

    // Upstream FIFO model (depth 16). hold masks availability so words can be preloaded.
    logic [DW-1:0] mem [16];
    logic [3:0]    wr_ptr, rd_ptr;
    logic [4:0]    cnt;
    logic          hold;
    logic          push;
    logic [DW-1:0] push_data;

    logic [DW-1:0] exp_q [$];
    int            checks;
    int            errors;
    int            pop_cnt;
    int            fire_cnt;

    always #5 clk = ~clk;

    fifo_pop_stream #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .buf_count  (buf_count)
    );

    assign fifo_empty = (cnt == 5'd0) | hold;

    always @(posedge clk) begin
        if (rst) begin
            cnt       <= 5'd0;
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            fifo_data <= '0;
        end else begin
            if (fifo_pop) begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 4'd1;
            end
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            cnt <= cnt + {4'd0, push} - {4'd0, fifo_pop};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        push      = 1'b1;
        push_data = w;
        exp_q.push_back(w);
        tick();
        push = 1'b0;
    endtask

    // Monitor: scoreboard on fires, stall stability, occupancy bound, no pop while empty.
    logic          prev_pop;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_w;
    initial begin
        pop_cnt    = 0;
        fire_cnt   = 0;
        prev_pop   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pop   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("occ_plus_inflight_le2",
                      32'(({1'b0, buf_count} + {2'b00, prev_pop}) <= 3'd2), 32'd1);
                if (fifo_pop) begin
                    pop_cnt++;
                    check("pop_while_empty", 32'((cnt != 5'd0) && !hold), 32'd1);
                end
                if (prev_stall) begin
                    check("stall_valid_held", 32'(down_valid), 32'd1);
                    check("stall_data_held", 32'(down_data), 32'(prev_data));
                end
                if (down_valid && down_ready) begin
                    fire_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h, required no word", down_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (down_data !== exp_w) begin
                            errors++;
                            $display("FAIL stream_data: got 0x%0h, required 0x%0h", down_data, exp_w);
                        end
                    end
                end
                prev_pop   = fifo_pop;
                prev_stall = down_valid && !down_ready;
                prev_data  = down_data;
            end
        end
    end

    // Stimulus
    int  p0, f0, pushed;
    bit  done;
    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        hold       = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        down_ready = 1'b0;

        // 1. reset then idle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_pop", 32'(fifo_pop), 32'd0);
            check("rst_valid", 32'(down_valid), 32'd0);
            check("rst_count", 32'(buf_count), 32'd0);
        end
        check("rst_data", 32'(down_data), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_pop", 32'(fifo_pop), 32'd0);
            check("idle_valid", 32'(down_valid), 32'd0);
            tick();
        end

        // 2. streaming 16 preloaded words
        down_ready = 1'b1;
        hold = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(DW'(i));
        p0 = pop_cnt;
        f0 = fire_cnt;
        hold = 1'b0;
        @(negedge clk);
        check("lat_pop_n", 32'(fifo_pop), 32'd1);
        check("lat_valid_n", 32'(down_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_valid_n1", 32'(down_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_valid_n2", 32'(down_valid), 32'd1);
        check("lat_data_n2", 32'(down_data), 32'h0001);
        for (int i = 0; i < 15; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(down_valid), 32'd1);
        end
        tick();
        @(negedge clk);
        check("stream_end_valid", 32'(down_valid), 32'd0);
        tick();
        check("stream_pops", 32'(pop_cnt - p0), 32'd16);
        check("stream_fires", 32'(fire_cnt - f0), 32'd16);

        // 3. backpressure
        down_ready = 1'b0;
        hold = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(16'h0100 + DW'(i));
        p0 = pop_cnt;
        hold = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        check("bp_pop_low", 32'(fifo_pop), 32'd0);
        check("bp_count", 32'(buf_count), 32'd2);
        check("bp_valid", 32'(down_valid), 32'd1);
        check("bp_head", 32'(down_data), 32'h0101);
        tick();
        check("bp_pops", 32'(pop_cnt - p0), 32'd2);
        down_ready = 1'b1;
        f0 = fire_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(down_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        check("bp_drain_end", 32'(down_valid), 32'd0);
        tick();
        check("bp_fires", 32'(fire_cnt - f0), 32'd8);

        // 4. random stalls, FIFO refilled while draining
        pushed = 0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            down_ready = 1'($urandom_range(0, 1));
            if (pushed < 20 && cnt < 5'd12 && $urandom_range(0, 1) == 1) begin
                push      = 1'b1;
                push_data = 16'h0200 + DW'(pushed);
                exp_q.push_back(push_data);
                pushed++;
            end
            tick();
            push = 1'b0;
            if (pushed == 20 && exp_q.size() == 0) done = 1'b1;
        end
        check("rand_drained", 32'(done), 32'd1);

        // 5. dry-up, then a late word
        down_ready = 1'b1;
        f0 = fire_cnt;
        push_word(16'h0301);
        push_word(16'h0302);
        push_word(16'h0303);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (fire_cnt - f0 == 3) done = 1'b1;
        end
        check("dry_three_fires", 32'(done), 32'd1);
        @(negedge clk);
        check("dry_pop_low", 32'(fifo_pop), 32'd0);
        check("dry_valid_low", 32'(down_valid), 32'd0);
        check("dry_count", 32'(buf_count), 32'd0);
        tick();
        hold = 1'b1;
        push_word(16'h0304);
        hold = 1'b0;
        @(negedge clk);
        check("late_pop", 32'(fifo_pop), 32'd1);
        check("late_valid_n", 32'(down_valid), 32'd0);
        tick();
        @(negedge clk);
        check("late_valid_n1", 32'(down_valid), 32'd0);
        tick();
        @(negedge clk);
        check("late_valid_n2", 32'(down_valid), 32'd1);
        check("late_data", 32'(down_data), 32'h0304);
        tick();

        // 6. reset with one word buffered and one in flight
        down_ready = 1'b0;
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(16'h0400 + DW'(i));
        hold = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        check("pre_rst_count", 32'(buf_count), 32'd1);
        check("pre_rst_pop", 32'(fifo_pop), 32'd0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        check("post_rst_valid", 32'(down_valid), 32'd0);
        check("post_rst_count", 32'(buf_count), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid2", 32'(down_valid), 32'd0);
        tick();
        down_ready = 1'b1;
        f0 = fire_cnt;
        push_word(16'h00AA);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (exp_q.size() == 0) done = 1'b1;
        end
        check("fresh_word_delivered", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("fresh_fires", 32'(fire_cnt - f0), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
